// File: rtl/video_pkg.sv
// Shared definitions for the video pixel shifter: parameter legality checks,
// a constant-foldable clog2 and the default idle-pixel pattern.
package video_pkg;

    // Widest legal pixel is 4 bits; the idle default is all ones, sliced to BPP.
    localparam logic [3:0] IDLE_PIXEL_ONES = 4'hF;

    // Ceiling log2 usable in constant expressions; clog2_f(1) == 0.
    function automatic int clog2_f(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Only 1, 2 and 4 bits per pixel are supported.
    function automatic bit bpp_legal(input int bpp);
        return (bpp == 1) || (bpp == 2) || (bpp == 4);
    endfunction

    // A word must split into a whole number of pixels.
    function automatic bit word_legal(input int word_width, input int bpp);
        return (word_width > 0) && (bpp > 0) && ((word_width % bpp) == 0);
    endfunction

    // Full parameter-set check used by the top level at elaboration.
    function automatic bit cfg_legal(input int word_width, input int bpp,
                                     input int clk_div, input int load_delay);
        return bpp_legal(bpp) && word_legal(word_width, bpp) &&
               (clk_div >= 1) && (clk_div <= 16) &&
               (load_delay >= 0) && (load_delay <= 3);
    endfunction

endpackage

// File: rtl/video_pixel_shifter_load_delay_line.sv
// Strobe-to-capture delay line. Only one capture may be in flight; a strobe
// arriving while one is pending is reported as dropped.
module load_delay_line #(
    parameter int LOAD_DELAY = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    output logic capture_o,
    output logic pending_o,
    output logic dropped_o
);

    if (LOAD_DELAY == 0) begin : g_direct
        // Data is valid in the strobe cycle itself, so nothing is ever pending.
        assign capture_o = strobe_i;
        assign pending_o = 1'b0;
        assign dropped_o = 1'b0;
    end else begin : g_pipe
        logic [LOAD_DELAY-1:0] pipe_q;
        logic [LOAD_DELAY-1:0] pipe_d;
        logic                  accept_s;

        // A capture stays pending up to and including its capture cycle.
        assign pending_o = |pipe_q;
        assign accept_s  = strobe_i & ~pending_o;
        assign dropped_o = strobe_i & pending_o;
        assign capture_o = pipe_q[LOAD_DELAY-1];

        // Advance the accepted-strobe token one stage per clock.
        always_comb begin
            pipe_d = (pipe_q << 1) | LOAD_DELAY'(accept_s);
        end

        // Delay-line state; reset discards any capture in flight.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end
    end

endmodule

// File: rtl/video_pixel_shifter.sv
// Video pixel shifter: captures VRAM words after a read strobe into a
// one-word prefetch buffer and shifts them out BPP bits every CLK_DIV clocks,
// reloading seamlessly and flagging overrun/underrun for timing debug.
module video_pixel_shifter
    import video_pkg::*;
#(
    parameter int             WORD_WIDTH = 8,
    parameter int             BPP        = 1,
    parameter int             CLK_DIV    = 2,
    parameter int             LOAD_DELAY = 1,
    parameter logic [BPP-1:0] IDLE_PIXEL = IDLE_PIXEL_ONES[BPP-1:0],
    parameter bit             INVERT     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadStrobe,
    input  logic [WORD_WIDTH-1:0] dataIn,
    input  logic                  blank,
    input  logic                  clearFlags,
    output logic [BPP-1:0]        pixel,
    output logic                  pixelStrobe,
    output logic                  busy,
    output logic                  bufferFull,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int PPW   = WORD_WIDTH / BPP;
    localparam int DIV_W = clog2_f(CLK_DIV) + 1;
    localparam int REM_W = clog2_f(PPW) + 1;

    localparam logic [WORD_WIDTH-1:0] FILL_WORD = {PPW{IDLE_PIXEL}};
    localparam logic [WORD_WIDTH-1:0] FILL_LOW  = WORD_WIDTH'(IDLE_PIXEL);
    localparam logic [BPP-1:0]        INV_MASK  = {BPP{INVERT}};
    localparam logic [DIV_W-1:0]      DIV_TC    = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_ONE   = DIV_W'(1);
    localparam logic [REM_W-1:0]      REM_FULL  = REM_W'(PPW);
    localparam logic [REM_W-1:0]      REM_ONE   = REM_W'(1);

    if (!cfg_legal(WORD_WIDTH, BPP, CLK_DIV, LOAD_DELAY)) begin : g_cfg_error
        $error("video_pixel_shifter: illegal WORD_WIDTH/BPP/CLK_DIV/LOAD_DELAY");
    end

    logic                  capture_s;
    logic                  pending_s;
    logic                  dropped_s;

    logic [WORD_WIDTH-1:0] shift_q,     shift_d;
    logic [REM_W-1:0]      remaining_q, remaining_d;
    logic [DIV_W-1:0]      div_q,       div_d;
    logic [WORD_WIDTH-1:0] buf_q,       buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  streaming_q, streaming_d;
    logic [BPP-1:0]        pixel_q,     pixel_d;
    logic                  strobe_q,    strobe_d;
    logic                  busy_q,      busy_d;
    logic                  overrun_q,   overrun_d;
    logic                  underrun_q,  underrun_d;

    logic                  consume_s;
    logic                  overwrite_s;
    logic                  underrun_set_s;

    load_delay_line #(
        .LOAD_DELAY (LOAD_DELAY)
    ) u_load_delay (
        .clk_i     (clk),
        .rst_i     (reset),
        .strobe_i  (loadStrobe),
        .capture_o (capture_s),
        .pending_o (pending_s),
        .dropped_o (dropped_s)
    );

    // Shifter, divider and prefetch-buffer next state plus flag updates.
    always_comb begin
        shift_d        = shift_q;
        remaining_d    = remaining_q;
        div_d          = div_q;
        buf_d          = buf_q;
        buf_valid_d    = buf_valid_q;
        streaming_d    = streaming_q;
        strobe_d       = 1'b0;
        consume_s      = 1'b0;
        overwrite_s    = 1'b0;
        underrun_set_s = 1'b0;

        if (remaining_q == '0) begin
            // Idle shifter: start a new stream as soon as a word is buffered.
            div_d = '0;
            if (buf_valid_q) begin
                shift_d     = buf_q;
                remaining_d = REM_FULL;
                streaming_d = 1'b1;
                strobe_d    = 1'b1;
                consume_s   = 1'b1;
            end else begin
                shift_d = shift_q;
            end
        end else if (div_q == DIV_TC) begin
            div_d = '0;
            if (remaining_q == REM_ONE) begin
                if (buf_valid_q) begin
                    // Last pixel done and next word ready: no idle gap.
                    shift_d     = buf_q;
                    remaining_d = REM_FULL;
                    strobe_d    = 1'b1;
                    consume_s   = 1'b1;
                end else begin
                    // Ran dry; only an error if a stream was in progress.
                    shift_d        = FILL_WORD;
                    remaining_d    = '0;
                    streaming_d    = 1'b0;
                    underrun_set_s = streaming_q;
                end
            end else begin
                shift_d     = (shift_q << BPP) | FILL_LOW;
                remaining_d = remaining_q - REM_ONE;
                strobe_d    = 1'b1;
            end
        end else begin
            div_d = div_q + DIV_ONE;
        end

        if (consume_s) begin
            buf_valid_d = 1'b0;
        end else begin
            buf_valid_d = buf_valid_q;
        end

        // A word arriving while the old one is consumed simply replaces it.
        if (capture_s) begin
            buf_d       = dataIn;
            buf_valid_d = 1'b1;
            overwrite_s = buf_valid_q & ~consume_s;
        end else begin
            buf_d = buf_q;
        end
    end

    // Registered output values derived from the next shifter state.
    always_comb begin
        pixel_d    = (blank ? IDLE_PIXEL : shift_d[WORD_WIDTH-1 -: BPP]) ^ INV_MASK;
        busy_d     = (remaining_d != '0);
        overrun_d  = (overrun_q & ~clearFlags) | dropped_s | overwrite_s;
        underrun_d = (underrun_q & ~clearFlags) | underrun_set_s;
    end

    // State and output registers with asynchronous reset to the idle picture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q     <= FILL_WORD;
            remaining_q <= '0;
            div_q       <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            streaming_q <= 1'b0;
            pixel_q     <= IDLE_PIXEL ^ INV_MASK;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            remaining_q <= remaining_d;
            div_q       <= div_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            streaming_q <= streaming_d;
            pixel_q     <= pixel_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    assign pixel       = pixel_q;
    assign pixelStrobe = strobe_q;
    assign busy        = busy_q;
    assign bufferFull  = buf_valid_q;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Directed testbench for video_pixel_shifter using three configurations:
// a = defaults, b = BPP 2 / CLK_DIV 1 / non-inverted, c = LOAD_DELAY 2.
module tb_video_pixel_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic       loadStrobe;
    logic [7:0] dataIn;
    logic       blank;
    logic       clearFlags;

    logic       pixel_a, strobe_a, busy_a, full_a, ovr_a, und_a;
    logic [1:0] pixel_b;
    logic       strobe_b, busy_b, full_b, ovr_b, und_b;
    logic       pixel_c, strobe_c, busy_c, full_c, ovr_c, und_c;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    video_pixel_shifter dut_a (
        .clk(clk), .reset(reset), .loadStrobe(loadStrobe), .dataIn(dataIn),
        .blank(blank), .clearFlags(clearFlags), .pixel(pixel_a),
        .pixelStrobe(strobe_a), .busy(busy_a), .bufferFull(full_a),
        .overrun(ovr_a), .underrun(und_a)
    );

    video_pixel_shifter #(
        .WORD_WIDTH(8), .BPP(2), .CLK_DIV(1), .LOAD_DELAY(1),
        .IDLE_PIXEL(2'b11), .INVERT(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .loadStrobe(loadStrobe), .dataIn(dataIn),
        .blank(blank), .clearFlags(clearFlags), .pixel(pixel_b),
        .pixelStrobe(strobe_b), .busy(busy_b), .bufferFull(full_b),
        .overrun(ovr_b), .underrun(und_b)
    );

    video_pixel_shifter #(
        .LOAD_DELAY(2)
    ) dut_c (
        .clk(clk), .reset(reset), .loadStrobe(loadStrobe), .dataIn(dataIn),
        .blank(blank), .clearFlags(clearFlags), .pixel(pixel_c),
        .pixelStrobe(strobe_c), .busy(busy_c), .bufferFull(full_c),
        .overrun(ovr_c), .underrun(und_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        loadStrobe = 1'b0;
        dataIn     = 8'h00;
        blank      = 1'b0;
        clearFlags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Issue one strobe with its word; with LOAD_DELAY 1 the first pixel of
    // the word is current after the third following edge.
    task automatic strobe_word(input logic [7:0] word);
        loadStrobe = 1'b1;
        dataIn     = word;
        tick();
        loadStrobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        if (pixel_a !== 1'b0) begin
            $display("FAIL reset_pixel_a: got %0d expected 0", pixel_a); tests_failed++;
        end
        tests_run++;
        if (pixel_b !== 2'd3) begin
            $display("FAIL reset_pixel_b: got %0d expected 3", pixel_b); tests_failed++;
        end
        tests_run++;
        if ({strobe_a, busy_a, full_a, ovr_a, und_a} !== 5'b00000) begin
            $display("FAIL reset_status_a: got %b expected 00000",
                     {strobe_a, busy_a, full_a, ovr_a, und_a});
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_single_word();
        int exp_seq [0:7];
        exp_seq = '{0, 1, 0, 1, 1, 0, 1, 0};
        do_reset();
        strobe_word(8'hA5);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            if (pixel_a !== exp_seq[i/2][0]) begin
                $display("FAIL single_pixel[%0d]: got %0d expected %0d", i, pixel_a, exp_seq[i/2]);
                tests_failed++;
            end
            tests_run++;
            if (busy_a !== 1'b1 || strobe_a !== ((i % 2) == 0)) begin
                $display("FAIL single_busy_strobe[%0d]: got busy=%0d strobe=%0d expected busy=1 strobe=%0d",
                         i, busy_a, strobe_a, (i % 2) == 0);
                tests_failed++;
            end
            tests_run++;
        end
        tick();
        if (pixel_a !== 1'b0 || busy_a !== 1'b0) begin
            $display("FAIL single_idle: got pixel=%0d busy=%0d expected pixel=0 busy=0", pixel_a, busy_a);
            tests_failed++;
        end
        tests_run++;
        if (und_a !== 1'b1) begin
            $display("FAIL single_underrun: got %0d expected 1", und_a); tests_failed++;
        end
        tests_run++;
        clearFlags = 1'b1;
        tick();
        clearFlags = 1'b0;
        if (und_a !== 1'b0) begin
            $display("FAIL single_clear: got underrun=%0d expected 0", und_a); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_back_to_back_words();
        int exp_seq [0:15];
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        do_reset();
        strobe_word(8'hF0);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) tick();
            if (pixel_a !== exp_seq[i/2][0] || busy_a !== 1'b1) begin
                $display("FAIL seamless_pixel[%0d]: got pixel=%0d busy=%0d expected pixel=%0d busy=1",
                         i, pixel_a, busy_a, exp_seq[i/2]);
                tests_failed++;
            end
            tests_run++;
            if (i == 2) begin
                loadStrobe = 1'b1;
                dataIn     = 8'h0F;
            end else if (i == 3) begin
                loadStrobe = 1'b0;
            end
        end
        if (ovr_a !== 1'b0 || und_a !== 1'b0) begin
            $display("FAIL seamless_flags: got overrun=%0d underrun=%0d expected 0 0", ovr_a, und_a);
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_bpp2();
        do_reset();
        strobe_word(8'h1B);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (pixel_b !== 2'(i) || strobe_b !== 1'b1) begin
                $display("FAIL bpp2_pixel[%0d]: got pixel=%0d strobe=%0d expected pixel=%0d strobe=1",
                         i, pixel_b, strobe_b, i);
                tests_failed++;
            end
            tests_run++;
        end
        tick();
        if (pixel_b !== 2'd3 || strobe_b !== 1'b0 || busy_b !== 1'b0) begin
            $display("FAIL bpp2_idle: got pixel=%0d strobe=%0d busy=%0d expected 3 0 0",
                     pixel_b, strobe_b, busy_b);
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_dropped_strobe();
        int strobes;
        do_reset();
        loadStrobe = 1'b1;
        dataIn     = 8'h3C;
        tick();
        clearFlags = 1'b1;
        tick();
        loadStrobe = 1'b0;
        clearFlags = 1'b0;
        if (ovr_c !== 1'b1) begin
            $display("FAIL drop_overrun: got %0d expected 1", ovr_c); tests_failed++;
        end
        tests_run++;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (strobe_c === 1'b1) strobes++;
        end
        if (strobes !== 8) begin
            $display("FAIL drop_single_word: got %0d pixel strobes expected 8", strobes);
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_overwrite();
        int exp_seq [0:15];
        exp_seq = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        do_reset();
        strobe_word(8'hA5);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) tick();
            if (pixel_a !== exp_seq[i/2][0]) begin
                $display("FAIL overwrite_pixel[%0d]: got %0d expected %0d", i, pixel_a, exp_seq[i/2]);
                tests_failed++;
            end
            tests_run++;
            if (i == 6) begin
                if (ovr_a !== 1'b1 || full_a !== 1'b1) begin
                    $display("FAIL overwrite_flag: got overrun=%0d full=%0d expected 1 1", ovr_a, full_a);
                    tests_failed++;
                end
                tests_run++;
            end
            if (i == 2) begin
                loadStrobe = 1'b1;
                dataIn     = 8'hFF;
            end else if (i == 3) begin
                loadStrobe = 1'b0;
            end else if (i == 4) begin
                loadStrobe = 1'b1;
                dataIn     = 8'h3C;
            end else if (i == 5) begin
                loadStrobe = 1'b0;
            end
        end
    endtask

    task automatic test_blank();
        int exp_seq [0:7];
        int expv;
        exp_seq = '{0, 1, 0, 1, 1, 0, 1, 0};
        do_reset();
        strobe_word(8'hA5);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            expv = (i >= 4 && i <= 7) ? 0 : exp_seq[i/2];
            if (pixel_a !== expv[0]) begin
                $display("FAIL blank_pixel[%0d]: got %0d expected %0d", i, pixel_a, expv);
                tests_failed++;
            end
            tests_run++;
            if (i == 4) begin
                if (strobe_a !== 1'b1) begin
                    $display("FAIL blank_keeps_shifting: got strobe=%0d expected 1", strobe_a);
                    tests_failed++;
                end
                tests_run++;
            end
            if (i == 3) blank = 1'b1;
            else if (i == 7) blank = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int strobes;
        do_reset();
        strobe_word(8'hA5);
        repeat (6) tick();
        if (pixel_a !== 1'b1) begin
            $display("FAIL areset_before: got %0d expected 1", pixel_a); tests_failed++;
        end
        tests_run++;
        loadStrobe = 1'b1;
        dataIn     = 8'h00;
        #2;
        reset = 1'b1;
        #1;
        if ({pixel_a, strobe_a, busy_a, full_a, ovr_a, und_a} !== 6'b000000) begin
            $display("FAIL areset_immediate: got %b expected 000000",
                     {pixel_a, strobe_a, busy_a, full_a, ovr_a, und_a});
            tests_failed++;
        end
        tests_run++;
        loadStrobe = 1'b0;
        tick();
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (strobe_a === 1'b1 || busy_a === 1'b1) strobes++;
        end
        if (strobes !== 0) begin
            $display("FAIL areset_quiet: got %0d active cycles expected 0", strobes);
            tests_failed++;
        end
        tests_run++;
    endtask

    initial begin
        reset      = 1'b1;
        loadStrobe = 1'b0;
        dataIn     = 8'h00;
        blank      = 1'b0;
        clearFlags = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back_words();
        test_bpp2();
        test_dropped_strobe();
        test_overwrite();
        test_blank();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/video_pixel_shifter.md
Name: video_pixel_shifter

Overview:
Parametrised successor of the SoC's single-byte pixel shift register. It captures video-RAM words LOAD_DELAY cycles after a VRAM read strobe. Each word lands in a one-word prefetch buffer, so a new fetch no longer truncates the word being shifted. Pixels are shifted out BPP bits at a time every CLK_DIV clocks, with seamless reload, blanking, and sticky overrun/underrun flags for timing debug.

Parameters:
WORD_WIDTH, 8, VRAM data word width; must be a multiple of BPP.
BPP, 1, bits per pixel; legal values 1, 2, 4.
CLK_DIV, 2, clocks per pixel; legal values 1..16.
LOAD_DELAY, 1, cycles from loadStrobe to dataIn valid; legal values 0..3.
IDLE_PIXEL, all ones (BPP bits), fill value shifted in and shown when empty or blanked.
INVERT, 1, if 1 the pixel output is bitwise inverted, giving an active-low monochrome pixel.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
loadStrobe  input  1  VRAM read cycle detected (strobe & ~write & address in VRAM window)
dataIn  input  WORD_WIDTH  memory read data; sampled LOAD_DELAY cycles after an accepted strobe
blank  input  1  high = force IDLE_PIXEL on output (sync/border); shifting continues
clearFlags  input  1  synchronous clear of overrun/underrun
pixel  output  BPP  current pixel (registered state, INVERT applied)
pixelStrobe  output  1  one-cycle pulse when a new pixel becomes current
busy  output  1  shifter holds at least one unshifted pixel
bufferFull  output  1  prefetch buffer valid
overrun  output  1  sticky: strobe dropped or buffer overwritten
underrun  output  1  sticky: shifter ran dry while streaming

Behaviour:
- Reset (async): shifter = IDLE fill, remaining = 0, divider = 0, buffer invalid, delay line cleared, streaming = 0. Outputs: pixel = IDLE_PIXEL^INVERT, pixelStrobe 0, busy 0, bufferFull 0, overrun 0, underrun 0. Reset mid-operation discards any pending capture.
- Capture pipeline: a strobe is accepted only if no capture is pending. A strobe while a capture is pending is dropped and sets overrun.
  - LOAD_DELAY = 0: dataIn is captured in the strobe cycle.
  - Otherwise: captured exactly LOAD_DELAY cycles after the strobe cycle.
- Buffer write: the captured word is written to the buffer. If the buffer is already valid and not being consumed in the same cycle, the newest word overwrites it and overrun is set.
- PPW = WORD_WIDTH/BPP pixels per word. remaining counts 0..PPW.
- Divider: counts 0..CLK_DIV-1 while busy. Terminal count (TC) = divider == CLK_DIV-1.
- Shifter empty (remaining 0) and buffer valid: load next cycle. remaining = PPW, divider = 0, buffer invalid, streaming = 1, pixelStrobe = 1.
- TC with remaining > 1: shift left by BPP, fill IDLE_PIXEL, remaining -1, pixelStrobe = 1.
- TC with remaining == 1:
  - Buffer valid: seamless reload, no idle pixel inserted.
  - Buffer empty: remaining = 0, output = IDLE_PIXEL, and underrun is set if streaming. streaming clears.
- Simultaneous capture and buffer consume in the same cycle: consume the old word, store the new one; no overrun.
- Current pixel = shifter[WORD_WIDTH-1 -: BPP]. Output = (blank ? IDLE_PIXEL : current) ^ {BPP{INVERT}}.
- blank masks the output only. It does not stall the divider or the shifter.
- clearFlags clears overrun and underrun. A flag-setting event in the same cycle wins.
- Arithmetic: divider width clog2(CLK_DIV)+1, remaining width clog2(PPW)+1. No wrap beyond the ranges above.

Decomposition:
- Shared package video_pkg: pixel-depth legality checks (BPP ∈ {1,2,4}, WORD_WIDTH % BPP == 0), clog2 helper, IDLE_PIXEL default constant.
- One natural sub-module, load_delay_line: parametrised strobe delay with pending flag. It yields a capture pulse and a "pending" signal used for strobe rejection.
- Shifter, divider and buffer stay in the top module.

Test Plan:
- Defaults, 0xA5 captured 1 cycle after strobe:
  - pixel (inverted) sequence 0,1,0,1,1,0,1,0, each held 2 clocks.
  - busy for 16 clocks, then pixel = 0 (idle).
  - underrun = 1 (stream ended with no next word); clearFlags -> 0.
- Two words 0xF0 then 0x0F, second strobe issued during first word's shifting:
  - 16 consecutive pixels with no idle gap; no overrun; no underrun.
- BPP=2, CLK_DIV=1, word 0x1B:
  - pixel (INVERT=0) = 0,1,2,3 on consecutive cycles, pixelStrobe high each cycle.
  - afterwards pixel = 3 (idle).
- Back-to-back strobes on cycles n, n+1 with LOAD_DELAY=2:
  - second strobe dropped, overrun = 1, only one word shifted.
- Three captures while shifter is busy:
  - third capture overwrites buffer, overrun = 1; last word shifted after the current one.
- blank asserted mid-word, and reset asserted mid-word:
  - blank: output idle during blank; after deassert, output matches the divider/shifter timeline (e.g. fifth pixel).
  - async reset: all outputs return to reset values immediately, with no further pixelStrobe.
